// File: rtl/ndp_sequencer.sv
// NDP core sequencer: reset/start/finish pulse generation, job count, errors.
// Define NDP_SEQ_TIMEOUT_EN to build the RUN timeout counter and err_timeout.
module ndp_sequencer #(
  parameter int unsigned RST_CYCLES = 4,
  parameter int unsigned FIN_CYCLES = 2,
  parameter int unsigned TMO_W      = 16
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [TMO_W-1:0] cmd_tmo,
  input  logic             abort,
  input  logic             err_clr,
  input  logic             calc_done,
  output logic             ndp_reset,
  output logic             ndp_start,
  output logic             ndp_finish,
  output logic             busy,
  output logic             err_timeout,
  output logic             err_illegal,
  output logic [7:0]       jobs_done
);

  localparam logic [7:0] RST_LAST = 8'(RST_CYCLES - 1);
  localparam logic [7:0] FIN_LAST = 8'(FIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_START,
    S_WAIT,
    S_FIN
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [7:0] cnt;
  logic [7:0] cnt_nx;
  logic       cd_q;
  logic       cd_s;
  logic       accept;
  logic       op_rst;
  logic       op_run;
  logic       op_fin;
  logic       op_ill;
  logic       ld_tmo;
  logic       set_tmo;
  logic       set_ill;
  logic       job_inc;
  logic       tmo_hit;

  assign cmd_ready = (state == S_IDLE) && !abort;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state != S_IDLE);

  assign op_rst = (cmd_op == 2'b00);
  assign op_run = (cmd_op == 2'b01);
  assign op_fin = (cmd_op == 2'b10);
  assign op_ill = (cmd_op == 2'b11);

`ifdef NDP_SEQ_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_lat;
  logic [TMO_W-1:0] tmo_cnt;
  logic             err_tmo_q;

  // tmo_cnt holds (WAIT cycles elapsed - 1) while evaluating WAIT
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      tmo_lat   <= '0;
      tmo_cnt   <= '0;
      err_tmo_q <= 1'b0;
    end else begin
      if (ld_tmo)
        tmo_lat <= cmd_tmo;
      tmo_cnt <= (state == S_WAIT) ? tmo_cnt + 1'b1 : '0;
      if (set_tmo)
        err_tmo_q <= 1'b1;
      else if (err_clr)
        err_tmo_q <= 1'b0;
    end
  end

  assign tmo_hit = (tmo_lat != '0) &&
                   (tmo_cnt == tmo_lat - 1'b1);
  assign err_timeout = err_tmo_q;
`else
  logic unused_tmo;

  assign unused_tmo  = ^{cmd_tmo, ld_tmo, set_tmo};
  assign tmo_hit     = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ld_tmo   = 1'b0;
    set_tmo  = 1'b0;
    set_ill  = 1'b0;
    job_inc  = 1'b0;
    if (abort) begin
      state_nx = S_RST;
      cnt_nx   = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            unique case (1'b1)
              op_rst: begin
                state_nx = S_RST;
                cnt_nx   = '0;
              end
              op_run: begin
                state_nx = S_START;
                ld_tmo   = 1'b1;
              end
              op_fin: begin
                state_nx = S_FIN;
                cnt_nx   = '0;
              end
              op_ill: set_ill = 1'b1;
            endcase
          end
        end
        S_RST: begin
          if (cnt == RST_LAST)
            state_nx = S_IDLE;
          else
            cnt_nx = cnt + 8'd1;
        end
        S_START: state_nx = S_WAIT;
        S_WAIT: begin
          // completion beats a coincident timeout
          if (cd_s) begin
            state_nx = S_FIN;
            cnt_nx   = '0;
            job_inc  = 1'b1;
          end else if (tmo_hit) begin
            state_nx = S_FIN;
            cnt_nx   = '0;
            set_tmo  = 1'b1;
          end
        end
        S_FIN: begin
          if (cnt == FIN_LAST)
            state_nx = S_IDLE;
          else
            cnt_nx = cnt + 8'd1;
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // pulse outputs are flops decoded from the next state
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cnt         <= '0;
      cd_q        <= 1'b0;
      cd_s        <= 1'b0;
      ndp_reset   <= 1'b0;
      ndp_start   <= 1'b0;
      ndp_finish  <= 1'b0;
      err_illegal <= 1'b0;
      jobs_done   <= '0;
    end else begin
      cnt        <= cnt_nx;
      cd_q       <= calc_done;
      cd_s       <= cd_q;
      ndp_reset  <= (state_nx == S_RST);
      ndp_start  <= (state_nx == S_START);
      ndp_finish <= (state_nx == S_FIN);
      if (job_inc)
        jobs_done <= jobs_done + 8'd1;
      if (set_ill)
        err_illegal <= 1'b1;
      else if (err_clr)
        err_illegal <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ndp_sequencer.sv
// Scoreboard bench for ndp_sequencer: expected pulse bursts are queued,
// a negedge monitor pops and compares each burst as it ends.
module tb_ndp_sequencer;

  localparam int K_RST = 0;
  localparam int K_STA = 1;
  localparam int K_FIN = 2;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [15:0] cmd_tmo = '0;
  logic        abort = 1'b0;
  logic        err_clr = 1'b0;
  logic        calc_done = 1'b0;
  logic        ndp_reset;
  logic        ndp_start;
  logic        ndp_finish;
  logic        busy;
  logic        err_timeout;
  logic        err_illegal;
  logic [7:0]  jobs_done;

  ndp_sequencer #(
    .RST_CYCLES(4),
    .FIN_CYCLES(2),
    .TMO_W(16)
  ) dut (
    .HCLK(HCLK),
    .HRESETn(HRESETn),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_tmo(cmd_tmo),
    .abort(abort),
    .err_clr(err_clr),
    .calc_done(calc_done),
    .ndp_reset(ndp_reset),
    .ndp_start(ndp_start),
    .ndp_finish(ndp_finish),
    .busy(busy),
    .err_timeout(err_timeout),
    .err_illegal(err_illegal),
    .jobs_done(jobs_done)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    int         kind;
    int         len;
    logic       bsy;
    logic [7:0] jobs;
    logic       errt;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   rl = 0;
  int   sl = 0;
  int   fl = 0;

  function automatic void check(string name, longint act, longint req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endfunction

  function automatic void push(int k, int len, logic b,
                               logic [7:0] j, logic e);
    exp_t x;
    x.kind = k;
    x.len  = len;
    x.bsy  = b;
    x.jobs = j;
    x.errt = e;
    sb.push_back(x);
  endfunction

  function automatic void observe(int k, int len);
    exp_t x;
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL sb_empty: got burst kind %0d len %0d, expected none",
               k, len);
    end else begin
      x = sb.pop_front();
      check("burst_kind", k, x.kind);
      check("burst_len", len, x.len);
      check("burst_busy", busy, x.bsy);
      check("burst_jobs", jobs_done, x.jobs);
      check("burst_errt", err_timeout, x.errt);
    end
  endfunction

  always @(negedge HCLK) begin
    if (!HRESETn) begin
      rl = 0;
      sl = 0;
      fl = 0;
    end else begin
      check("onehot", $onehot0({ndp_reset, ndp_start, ndp_finish}), 1);
      if (ndp_reset) rl++;
      else if (rl > 0) begin observe(K_RST, rl); rl = 0; end
      if (ndp_start) sl++;
      else if (sl > 0) begin observe(K_STA, sl); sl = 0; end
      if (ndp_finish) fl++;
      else if (fl > 0) begin observe(K_FIN, fl); fl = 0; end
    end
  end

  task automatic send(input logic [1:0] op, input logic [15:0] tmo);
    @(negedge HCLK);
    for (int i = 0; i < 200 && !cmd_ready; i++) @(negedge HCLK);
    if (!cmd_ready) check("send_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_tmo   = tmo;
    @(posedge HCLK);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge HCLK);
      if (!busy) return;
      n++;
    end
    check("wait_idle_busy", busy, 0);
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    @(posedge HCLK);
    #1 abort = 1'b0;
  endtask

  task automatic run_job(input logic [15:0] tmo, input int dly);
    int n;
    send(2'b01, tmo);
    repeat (dly) @(negedge HCLK);
    calc_done = 1'b1;
    for (int i = 0; i < 100 && !ndp_finish; i++) @(negedge HCLK);
    if (!ndp_finish) check("job_finish_seen", ndp_finish, 1);
    calc_done = 1'b0;
    wait_idle(n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge HCLK);
    check("inrst_busy", busy, 0);
    check("inrst_reset", ndp_reset, 0);
    HRESETn = 1'b1;
    @(negedge HCLK);
    check("por_ready", cmd_ready, 1);
    check("por_busy", busy, 0);
    check("por_pulses", {ndp_reset, ndp_start, ndp_finish}, 0);
    check("por_jobs", jobs_done, 0);
    check("por_errs", {err_timeout, err_illegal}, 0);

    // RESET command
    push(K_RST, 4, 1'b0, 8'd0, 1'b0);
    send(2'b00, '0);
    wait_idle(n);
    check("rst_busy_cycles", n, 4);
    check("rst_ready", cmd_ready, 1);

    // RUN, no timeout, done after 10 cycles
    push(K_STA, 1, 1'b1, 8'd0, 1'b0);
    push(K_FIN, 2, 1'b0, 8'd1, 1'b0);
    run_job(16'd0, 10);
    check("run_jobs", jobs_done, 1);
    check("run_errt", err_timeout, 0);

    // RUN with timeout 20, calc_done never raised
    push(K_STA, 1, 1'b1, 8'd1, 1'b0);
`ifdef NDP_SEQ_TIMEOUT_EN
    push(K_FIN, 2, 1'b0, 8'd1, 1'b1);
    send(2'b01, 16'd20);
    n = 0;
    for (int i = 0; i < 100 && !ndp_finish; i++) begin
      @(negedge HCLK);
      if (busy && !ndp_start && !ndp_finish) n++;
    end
    check("tmo_wait_cycles", n, 20);
    wait_idle(n);
    check("tmo_err", err_timeout, 1);
    check("tmo_jobs", jobs_done, 1);
    @(negedge HCLK);
    err_clr = 1'b1;
    @(negedge HCLK);
    err_clr = 1'b0;
    check("tmo_clr", err_timeout, 0);
`else
    send(2'b01, 16'd20);
    repeat (40) @(negedge HCLK);
    check("notmo_busy", busy, 1);
    check("notmo_fin", ndp_finish, 0);
    check("notmo_err", err_timeout, 0);
    push(K_RST, 4, 1'b0, 8'd1, 1'b0);
    pulse_abort();
    wait_idle(n);
`endif

    // abort in WAIT
    push(K_STA, 1, 1'b1, 8'd1, 1'b0);
    push(K_RST, 4, 1'b0, 8'd1, 1'b0);
    send(2'b01, 16'd0);
    repeat (5) @(negedge HCLK);
    pulse_abort();
    wait_idle(n);
    check("abw_busy_cycles", n, 4);
    check("abw_jobs", jobs_done, 1);

    // abort in RST restarts the count
    push(K_RST, 6, 1'b0, 8'd1, 1'b0);
    send(2'b00, '0);
    @(negedge HCLK);
    @(negedge HCLK);
    pulse_abort();
    wait_idle(n);
    check("abr_busy_cycles", n, 4);

    // FINISH command
    push(K_FIN, 2, 1'b0, 8'd1, 1'b0);
    send(2'b10, '0);
    wait_idle(n);
    check("fin_busy_cycles", n, 2);

    // illegal opcode, then set-beats-clear, then clear
    send(2'b11, '0);
    @(negedge HCLK);
    check("ill_err", err_illegal, 1);
    check("ill_busy", busy, 0);
    check("ill_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = 2'b11;
    err_clr   = 1'b1;
    @(posedge HCLK);
    #1 cmd_valid = 1'b0;
    err_clr = 1'b0;
    @(negedge HCLK);
    check("ill_set_wins", err_illegal, 1);
    err_clr = 1'b1;
    @(negedge HCLK);
    err_clr = 1'b0;
    check("ill_clr", err_illegal, 0);

    // reset mid-sequence
    send(2'b00, '0);
    @(negedge HCLK);
    HRESETn = 1'b0;
    #1;
    check("mid_rst_pulse", ndp_reset, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_jobs", jobs_done, 0);
    @(negedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
    check("mid_rst_idle", busy, 0);

    // 256 jobs: jobs_done wraps back to 0
    for (int k = 0; k < 256; k++) begin
      push(K_STA, 1, 1'b1, 8'(k), 1'b0);
      push(K_FIN, 2, 1'b0, 8'(k + 1), 1'b0);
      run_job(16'd0, 2);
    end
    check("wrap_jobs", jobs_done, 0);

    @(negedge HCLK);
    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ndp_sequencer.md
NDP_SEQUENCER -- requirements
Module: ndp_sequencer

Interface
REQ-001 The block SHALL have a parameter RST_CYCLES, default 4: the number of cycles ndp_reset is held high per reset sequence (legal range 1..255).
REQ-002 The block SHALL have a parameter FIN_CYCLES, default 2: the number of cycles ndp_finish is held high per finish sequence (legal range 1..255).
REQ-003 The block SHALL have a parameter TMO_W, default 16: the width of the timeout field and timeout counter.
REQ-004 Port HCLK, input, 1 bit: the single clock; all state is rising-edge.
REQ-005 Port HRESETn, input, 1 bit: asynchronous active-low reset.
REQ-006 Port cmd_valid, input, 1 bit: a command is offered.
REQ-007 Port cmd_ready, output, 1 bit: the sequencer accepts a command this cycle.
REQ-008 Port cmd_op, input, 2 bits: 00 = RESET, 01 = RUN, 10 = FINISH, 11 = illegal.
REQ-009 Port cmd_tmo, input, TMO_W bits: the RUN timeout in cycles; 0 means no timeout.
REQ-010 Port abort, input, 1 bit: force a reset sequence.
REQ-011 Port err_clr, input, 1 bit: clear the sticky error flags.
REQ-012 Port calc_done, input, 1 bit: NDP core completion flag, asynchronous to HCLK.
REQ-013 Port ndp_reset / ndp_start / ndp_finish, output, 1 bit each: drive the NDP core reset_in / start_in / finish_in.
REQ-014 Port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-015 Port err_timeout / err_illegal, output, 1 bit each: sticky error flags.
REQ-016 Port jobs_done, output, 8 bits: count of completed RUN jobs.

Function
REQ-017 calc_done SHALL pass through a 2-flop synchronizer before use; the synchronized value is calc_done_s.
REQ-018 The FSM states SHALL be IDLE, RST, START, WAIT, FIN.
REQ-019 cmd_ready SHALL be high only in IDLE with abort low; a command is accepted when cmd_valid and cmd_ready are both high.
REQ-020 An accepted RESET command SHALL move IDLE to RST; ndp_reset is high for exactly RST_CYCLES cycles, then the FSM returns to IDLE.
REQ-021 An accepted RUN command SHALL latch cmd_tmo and move to START; ndp_start is high for exactly 1 cycle, then the FSM enters WAIT.
REQ-022 In WAIT, calc_done_s = 1 SHALL move the FSM to FIN and increment jobs_done, wrapping from 255 to 0.
REQ-023 In WAIT with a non-zero latched timeout, reaching that many cycles without calc_done_s SHALL set err_timeout and move to FIN without incrementing jobs_done.
REQ-024 If calc_done_s and the timeout occur in the same cycle, done SHALL win: no error, jobs_done increments.
REQ-025 FIN SHALL hold ndp_finish high for exactly FIN_CYCLES cycles, then return to IDLE.
REQ-026 An accepted FINISH command SHALL enter FIN directly.
REQ-027 An accepted illegal opcode SHALL set err_illegal and leave the FSM in IDLE.
REQ-028 abort = 1 in any state SHALL move the FSM to RST on the next edge; the cycle counter restarts and the active command is dropped.
REQ-029 abort in RST SHALL restart the RST count.
REQ-030 err_clr SHALL clear both error flags; a set event in the same cycle SHALL win over the clear.
REQ-031 ndp_reset, ndp_start and ndp_finish SHALL be registered, mutually exclusive and glitch-free.

Reset
REQ-032 HRESETn low SHALL immediately force: state = IDLE, all outputs 0 except cmd_ready, which is 1 once HRESETn is high; counters 0; synchronizer 0; error flags 0; jobs_done 0.
REQ-033 Reset mid-sequence SHALL abandon the sequence with no pulse completion.

Configuration
REQ-034 Macro NDP_SEQ_TIMEOUT_EN defined: the timeout counter and err_timeout logic SHALL be present as specified above.
REQ-035 Macro NDP_SEQ_TIMEOUT_EN undefined: WAIT SHALL exit only on calc_done_s or abort, cmd_tmo is ignored, and err_timeout is tied to 0.

Verification
REQ-036 Scenario: RESET command with RST_CYCLES = 4 -> ndp_reset high for 4 cycles, busy high for 4 cycles, then cmd_ready = 1.
REQ-037 Scenario: RUN with cmd_tmo = 0 and calc_done raised 10 cycles later -> 1-cycle ndp_start, then 2-cycle ndp_finish, jobs_done = 1, no error.
REQ-038 Scenario: RUN with cmd_tmo = 20 and calc_done never raised -> err_timeout set after 20 WAIT cycles, FIN runs, jobs_done unchanged; with the macro undefined the FSM stays in WAIT.
REQ-039 Scenario: abort pulsed in WAIT -> RST for 4 cycles, then IDLE, jobs_done unchanged.
REQ-040 Scenario: cmd_op = 11 -> err_illegal = 1 and the FSM stays in IDLE; err_clr then clears it.
REQ-041 Scenario: 256 RUN jobs each completing -> jobs_done wraps to 0.
